// File: rtl/fp_status_monitor_pkg.sv
// fp_mon_pkg: check ids, pstatus bit positions and monitor FSM states for fp_status_monitor.
package fp_mon_pkg;
  localparam int N_CHK = 7;
  typedef enum logic [2:0] {
    CHK_ZERO = 3'd0,
    CHK_INF  = 3'd1,
    CHK_NAN  = 3'd2,
    CHK_TINY = 3'd3,
    CHK_HUGE = 3'd4,
    CHK_EXCL = 3'd5,
    CHK_RSVD = 3'd6
  } chk_id_e;
  localparam int PS_ZERO    = 0;
  localparam int PS_INF     = 1;
  localparam int PS_NAN     = 2;
  localparam int PS_TINY    = 3;
  localparam int PS_HUGE    = 4;
  localparam int PS_INEXACT = 5;
  typedef enum logic [1:0] {
    WARMUP = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } mon_state_e;
endpackage

// File: rtl/fp_status_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear taking priority over increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_count <= '0;
    else if (i_clr) r_count <= '0;
    else if (i_inc && !(&r_count)) r_count <= r_count + CNT_W'(1);
  assign o_count = r_count;
endmodule

// File: rtl/fp_status_monitor.sv
// fp_status_monitor: runtime checker of FP multiplier pstatus against pz and delayed operand exponents.
module fp_status_monitor
  import fp_mon_pkg::*;
#(
  parameter int EXP_W        = 8,
  parameter int MAN_W        = 23,
  parameter int LATENCY      = 2,
  parameter int CNT_W        = 16,
  parameter int STOP_ON_FAIL = 0,
  localparam int W           = 1 + EXP_W + MAN_W
) (
  input  logic             pclk,
  input  logic             prst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [W-1:0]     pa,
  input  logic [W-1:0]     pb,
  input  logic [W-1:0]     pz,
  input  logic [7:0]       pstatus,
  output logic [6:0]       err_vec,
  output logic             err_any,
  input  logic [2:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_rd,
  output logic             ff_valid,
  output logic [2:0]       ff_id,
  output logic [W-1:0]     ff_z
);
  localparam int WC_W = $clog2(LATENCY + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-2:0] MIN_NORM = {{(EXP_W-1){1'b0}}, 1'b1, {MAN_W{1'b0}}};
  localparam logic [W-2:0] MAX_NORM = {EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
  mon_state_e                  r_state;
  logic [WC_W-1:0]             r_warm;
  logic [LATENCY-1:0][EXP_W-1:0] r_ha, r_hb;
  logic [LATENCY-1:0]          r_hv;
  logic [N_CHK-1:0]            r_err, w_fail;
  logic                        r_ffv;
  logic [2:0]                  r_ffid, w_ffid;
  logic [W-1:0]                r_ffz;
  logic [EXP_W-1:0]            w_ez, w_ea, w_eb;
  logic                        w_act, w_nan_ops, w_unused;
  logic [CNT_W-1:0]            w_cnt [8];
  assign w_ez = pz[W-2:MAN_W];
  assign w_ea = r_ha[LATENCY-1];
  assign w_eb = r_hb[LATENCY-1];
  assign w_act = en && r_state != FROZEN;
  assign w_nan_ops = r_hv[LATENCY-1] &&
    ((w_ea == '0 && w_eb == EXP_ONES) || (w_ea == EXP_ONES && w_eb == '0));
  assign w_unused = ^{pa[W-1], pa[MAN_W-1:0], pb[W-1], pb[MAN_W-1:0], pz[W-1], pstatus[PS_INEXACT]};
  always_comb begin
    w_fail = '0;
    w_fail[CHK_ZERO] = pstatus[PS_ZERO] && w_ez != '0;
    w_fail[CHK_INF]  = pstatus[PS_INF] && w_ez != EXP_ONES;
    w_fail[CHK_NAN]  = pstatus[PS_NAN] && !w_nan_ops && r_state == RUN;
    w_fail[CHK_TINY] = pstatus[PS_TINY] && w_ez != '0 && pz[W-2:0] != MIN_NORM;
    w_fail[CHK_HUGE] = pstatus[PS_HUGE] && w_ez != EXP_ONES && pz[W-2:0] != MAX_NORM;
    w_fail[CHK_EXCL] = pstatus[PS_ZERO] && pstatus[PS_INF];
    w_fail[CHK_RSVD] = pstatus[7:6] != 2'b00;
    w_fail = w_act ? w_fail : '0;
    w_ffid = '0;
    for (int i = N_CHK - 1; i >= 0; i--) w_ffid = w_fail[i] ? 3'(i) : w_ffid;
  end
  always_ff @(posedge pclk or negedge prst_n)
    if (!prst_n) begin
      r_ha <= '0;
      r_hb <= '0;
      r_hv <= '0;
    end else if (clr) begin
      r_ha <= '0;
      r_hb <= '0;
      r_hv <= '0;
    end else if (en) begin
      r_ha[0] <= pa[W-2:MAN_W];
      r_hb[0] <= pb[W-2:MAN_W];
      r_hv[0] <= 1'b1;
      for (int i = 1; i < LATENCY; i++) begin
        r_ha[i] <= r_ha[i-1];
        r_hb[i] <= r_hb[i-1];
        r_hv[i] <= r_hv[i-1];
      end
    end
  // WARMUP masks NAN until the operand history holds LATENCY real samples
  always_ff @(posedge pclk or negedge prst_n)
    if (!prst_n) begin
      r_state <= WARMUP;
      r_warm  <= '0;
    end else if (clr) begin
      r_state <= WARMUP;
      r_warm  <= '0;
    end else if (en && r_state == WARMUP) begin
      r_warm  <= r_warm + WC_W'(1);
      r_state <= r_warm == WC_W'(LATENCY - 1) ? RUN : WARMUP;
    end else if (r_state == RUN && STOP_ON_FAIL != 0 && |w_fail) begin
      r_state <= FROZEN;
    end
  always_ff @(posedge pclk or negedge prst_n)
    if (!prst_n) begin
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffid <= '0;
      r_ffz  <= '0;
    end else if (clr) begin
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffid <= '0;
      r_ffz  <= '0;
    end else begin
      r_err <= r_err | w_fail;
      if (|w_fail && !r_ffv) begin
        r_ffv  <= 1'b1;
        r_ffid <= w_ffid;
        r_ffz  <= pz;
      end
    end
  for (genvar i = 0; i < N_CHK; i++) begin : g_cnt
    sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (pclk),
      .rst_n   (prst_n),
      .i_inc   (w_fail[i]),
      .i_clr   (clr),
      .o_count (w_cnt[i])
    );
  end
  assign w_cnt[7]  = '0;
  assign cnt_rd    = w_cnt[cnt_sel];
  assign err_vec   = r_err;
  assign err_any   = |r_err;
  assign ff_valid  = r_ffv;
  assign ff_id     = r_ffid;
  assign ff_z      = r_ffz;
endmodule

// File: tb/tb_fp_status_monitor.sv
// tb_fp_status_monitor: directed checks of fp_status_monitor (default, 2-bit counter, stop-on-fail variants).
module tb_fp_status_monitor;
  localparam int W = 32;
  localparam logic [31:0] ONE  = 32'h3F800000;
  localparam logic [31:0] TWO  = 32'h40000000;
  localparam logic [31:0] INF  = 32'h7F800000;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  logic          pclk = 1'b0, prst_n = 1'b0, en = 1'b0, clr = 1'b0;
  logic [W-1:0]  pa = '0, pb = '0, pz = '0;
  logic [7:0]    pstatus = '0;
  logic [2:0]    cnt_sel = '0;
  logic [6:0]    e0, e1, e2;
  logic          a0, a1, a2, v0, v1, v2;
  logic [2:0]    i0, i1, i2;
  logic [W-1:0]  z0, z1, z2;
  logic [15:0]   c0, c2;
  logic [1:0]    c1;
  int n_chk = 0, n_err = 0;
  always #5 pclk = ~pclk;
  fp_status_monitor dut (
    .pclk(pclk), .prst_n(prst_n), .en(en), .clr(clr), .pa(pa), .pb(pb), .pz(pz),
    .pstatus(pstatus), .err_vec(e0), .err_any(a0), .cnt_sel(cnt_sel), .cnt_rd(c0),
    .ff_valid(v0), .ff_id(i0), .ff_z(z0));
  fp_status_monitor #(.CNT_W(2)) dut_sat (
    .pclk(pclk), .prst_n(prst_n), .en(en), .clr(clr), .pa(pa), .pb(pb), .pz(pz),
    .pstatus(pstatus), .err_vec(e1), .err_any(a1), .cnt_sel(cnt_sel), .cnt_rd(c1),
    .ff_valid(v1), .ff_id(i1), .ff_z(z1));
  fp_status_monitor #(.STOP_ON_FAIL(1)) dut_stop (
    .pclk(pclk), .prst_n(prst_n), .en(en), .clr(clr), .pa(pa), .pb(pb), .pz(pz),
    .pstatus(pstatus), .err_vec(e2), .err_any(a2), .cnt_sel(cnt_sel), .cnt_rd(c2),
    .ff_valid(v2), .ff_id(i2), .ff_z(z2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [31:0] z, input logic [7:0] st);
    pa = a; pb = b; pz = z; pstatus = st; en = 1'b1;
    @(posedge pclk); #1;
    en = 1'b0;
  endtask
  task automatic do_clr;
    clr = 1'b1; pstatus = 8'h00;
    @(posedge pclk); #1;
    clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_err", 32'(e0), 0);
    chk("rst_any", 32'(a0), 0);
    chk("rst_ffv", 32'(v0), 0);
    chk("rst_cnt", 32'(c0), 0);
    #2 prst_n = 1'b1;
    @(posedge pclk); #1;
    step(ONE, ONE, TWO, 8'h05);
    chk("warm_err", 32'(e0), 32'h01);
    chk("warm_ffid", 32'(i0), 0);
    chk("warm_ffz", z0, TWO);
    do_clr;
    chk("clr_err", 32'(e0), 0);
    chk("clr_ffv", 32'(v0), 0);
    repeat (3) step(ONE, TWO, TWO, 8'h00);
    chk("legal_err", 32'(e0), 0);
    chk("legal_ffv", 32'(v0), 0);
    for (int i = 0; i < 8; i++) begin
      cnt_sel = 3'(i); #1;
      chk($sformatf("legal_cnt%0d", i), 32'(c0), 0);
    end
    cnt_sel = 3'd0;
    step(ONE, TWO, ONE, 8'h01);
    #1;
    chk("zero_err", 32'(e0), 32'h01);
    chk("zero_any", 32'(a0), 1);
    chk("zero_cnt", 32'(c0), 1);
    chk("zero_ffv", 32'(v0), 1);
    chk("zero_ffid", 32'(i0), 0);
    chk("zero_ffz", z0, ONE);
    step(32'h0, INF, TWO, 8'h00);
    step(ONE, ONE, TWO, 8'h00);
    step(ONE, ONE, QNAN, 8'h04);
    chk("nan_ok", 32'(e0), 32'h01);
    step(INF, 32'h0, TWO, 8'h00);
    step(ONE, ONE, TWO, 8'h00);
    step(ONE, ONE, QNAN, 8'h04);
    chk("nan_ok_rev", 32'(e0), 32'h01);
    step(32'h0, ONE, TWO, 8'h00);
    step(ONE, ONE, TWO, 8'h00);
    step(ONE, ONE, QNAN, 8'h04);
    chk("nan_bad", 32'(e0), 32'h05);
    cnt_sel = 3'd2; #1;
    chk("nan_cnt", 32'(c0), 1);
    chk("nan_ffz_held", z0, ONE);
    do_clr;
    step(ONE, TWO, 32'h0, 8'h03);
    chk("excl_err", 32'(e0), 32'h22);
    chk("excl_ffid", 32'(i0), 1);
    chk("excl_ffz", z0, 0);
    do_clr;
    step(ONE, TWO, 32'h00800000, 8'h08);
    step(ONE, TWO, 32'h7F7FFFFF, 8'h10);
    step(ONE, TWO, TWO, 8'h20);
    step(ONE, TWO, 32'h0, 8'h08);
    step(ONE, TWO, INF, 8'h10);
    chk("bound_pass", 32'(e0), 0);
    step(ONE, TWO, 32'h00800001, 8'h08);
    chk("tiny_err", 32'(e0), 32'h08);
    chk("tiny_ffid", 32'(i0), 3);
    step(ONE, TWO, 32'h7F7FFFFE, 8'h10);
    chk("huge_err", 32'(e0), 32'h18);
    chk("huge_ffid", 32'(i0), 3);
    step(ONE, TWO, TWO, 8'h80);
    chk("rsvd_err", 32'(e0), 32'h58);
    cnt_sel = 3'd6; #1;
    chk("rsvd_cnt", 32'(c0), 1);
    cnt_sel = 3'd0;
    do_clr;
    repeat (5) step(ONE, TWO, ONE, 8'h01);
    chk("sat_cnt", 32'(c1), 3);
    chk("wide_cnt", 32'(c0), 5);
    do_clr;
    chk("sat_clr_err", 32'(e1), 0);
    chk("sat_clr_any", 32'(a1), 0);
    chk("sat_clr_cnt", 32'(c1), 0);
    chk("sat_clr_ffv", 32'(v1), 0);
    chk("sat_clr_ffid", 32'(i1), 0);
    chk("sat_clr_ffz", z1, 0);
    step(ONE, ONE, QNAN, 8'h04);
    chk("clr_warmup", 32'(e0), 0);
    repeat (2) step(ONE, TWO, TWO, 8'h00);
    step(ONE, TWO, ONE, 8'h01);
    chk("stop_err", 32'(e2), 32'h01);
    chk("stop_cnt", 32'(c2), 1);
    step(ONE, TWO, ONE, 8'h01);
    chk("frozen_cnt", 32'(c2), 1);
    chk("run_cnt", 32'(c0), 2);
    step(ONE, TWO, TWO, 8'h40);
    chk("frozen_err", 32'(e2), 32'h01);
    chk("run_err", 32'(e0), 32'h41);
    do_clr;
    step(ONE, TWO, ONE, 8'h01);
    chk("resume_err", 32'(e2), 32'h01);
    chk("resume_cnt", 32'(c2), 1);
    chk("resume_ffv", 32'(v2), 1);
    pstatus = 8'h41;
    repeat (3) @(posedge pclk);
    #1;
    chk("en_off_cnt", 32'(c2), 1);
    chk("pre_rst_err", 32'(e0), 32'h01);
    #2 prst_n = 1'b0;
    #1;
    chk("arst_err", 32'(e0), 0);
    chk("arst_any", 32'(a0), 0);
    chk("arst_cnt", 32'(c0), 0);
    chk("arst_ffv", 32'(v0), 0);
    chk("arst_ffz", z0, 0);
    chk("arst_stop_err", 32'(e2), 0);
    #10 prst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
